gearbox_block_lock: RTL and testbench
=====================================

# gearbox_block_lock

Block-lock controller for the 128b/132b receive path. Sits between the 128→132 gearbox and the link layer. Inspects the 4-bit header of every 132-bit block the gearbox emits and pulses `slip` back to the gearbox until header alignment is found. Declares `block_lock` and forwards only aligned, header-qualified blocks to the link layer.

## Interface
- `LOCK_GOOD`, 64: consecutive valid headers required to declare lock.
- `WIN_LEN`, 1024: monitoring window length in blocks while locked.
- `WIN_BAD`, 16: bad headers within one window that drop lock.
- `SLIP_WAIT`, 33: valid blocks ignored after a slip (gearbox refill).
- `clk` input 1: single clock, shared with the gearbox.
- `rst` input 1: asynchronous, active-high reset.
- `blk_in` input 132: gearbox output; header = `blk_in[131:128]`, payload = `blk_in[127:0]`.
- `blk_valid` input 1: `blk_in` qualifier, one block per asserted cycle.
- `slip` output 1: one-cycle pulse; gearbox shifts alignment by one bit.
- `block_lock` output 1: alignment achieved.
- `dout` output 128: registered payload.
- `dout_valid` output 1: `dout` qualifier, asserted only while locked.
- `dout_ctrl` output 1: 1 when the header was 4'b0011 (control block), 0 when 4'b1100 (data block).
- `bad_hdr_cnt` output 16: saturating count of bad headers seen while locked.

## Operation
- Header classes: 4'b1100 is data, 4'b0011 is control, all other values are bad.
- States: HUNT, SLIP_HOLD, CHECK, LOCKED.
- HUNT (reset state):
  - valid block with a good header → CHECK, `good_cnt`=1.
  - valid block with a bad header → pulse `slip`, `wait_cnt`=0, → SLIP_HOLD.
- SLIP_HOLD: counts valid blocks and ignores their content. After `SLIP_WAIT` of them → HUNT.
- CHECK:
  - good header → `good_cnt`+1. When the count reaches `LOCK_GOOD` → LOCKED, `block_lock`=1, window counters cleared.
  - bad header → pulse `slip`, → SLIP_HOLD, `good_cnt` cleared.
- LOCKED: `blk_cnt` counts valid blocks and `bad_cnt` counts bad headers.
  - `bad_cnt` reaching `WIN_BAD` → `block_lock`=0, pulse `slip`, → SLIP_HOLD. `bad_cnt`=WIN_BAD is checked before the window-end clear.
  - `blk_cnt` reaching `WIN_LEN` → both counters clear. The block in that cycle is counted in the closing window.
- Forwarding:
  - Only in LOCKED and only for good headers is `dout_valid`=1.
  - Bad-header blocks in LOCKED are dropped: `dout_valid`=0, `bad_hdr_cnt`+1 (saturates at 16'hFFFF).
- `blk_valid`=0 cycles: no state, counter or output-valid change; `dout_valid`=0.
- Counter widths: `good_cnt` 7b, `blk_cnt` 10b (compare against `WIN_LEN`-1 on the block being counted), `bad_cnt` 5b, `wait_cnt` 6b.
- Reset mid-operation forces HUNT immediately, whatever the current state.

## Timing
- Reset values: `slip`=0, `block_lock`=0, `dout`=0, `dout_valid`=0, `dout_ctrl`=0, `bad_hdr_cnt`=0. All counters are 0.
- Latency `blk_in` → `dout`/`dout_valid`/`dout_ctrl`: 1 cycle, registered.
- `slip` is registered and asserted the cycle after the offending block is sampled. It is never asserted on two consecutive cycles.
- `block_lock` rises and falls in the same edge as the state transition.
- The block that completes `LOCK_GOOD` is not forwarded; the first forwarded block is the next good one.
- Entering SLIP_HOLD from LOCKED also suppresses `dout_valid` for the failing block.
- The gearbox's periodic `blk_valid`=0 bubble (one in 33) must not disturb any count.

## Structure
- Shared package `gearbox_pkg`:
  - header constants `HDR_DATA`=4'b1100, `HDR_CTRL`=4'b0011.
  - state enum {HUNT, SLIP_HOLD, CHECK, LOCKED}.
  - widths 132/128/4.
- Registers use the existing `dfflr` flop primitive, with an async active-high reset variant.
- No further sub-module; FSM, counters and output register live in one module.

## Test plan
- Aligned stream: 64 blocks with header 4'b1100 → `block_lock` rises after the 64th. Block 65 payload 128'hA5.. appears on `dout` one cycle later with `dout_valid`=1, `dout_ctrl`=0.
- Misaligned start: header 4'b1010 → one `slip` pulse. The next 33 valid blocks are ignored even if bad, then hunting resumes. 3 bad starts → exactly 3 `slip` pulses.
- Locked loss: 15 bad headers inside a 1024-block window → stays locked, `bad_hdr_cnt`=15. A 16th bad header in the same window → `block_lock`=0, `slip` pulse.
- Window rollover: 15 bad in window 1, then 15 bad in window 2 → lock held, `bad_hdr_cnt`=30.
- Bubbles: `blk_valid` low 1 in every 33 cycles during lock acquisition → lock after exactly 64 valid good blocks.
- Async reset asserted in LOCKED mid-stream → all outputs 0 immediately. After release, 64 good blocks are needed again to lock.

Source files
------------

// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared widths, header codes and lock states for the 128b/132b receive path
package gearbox_pkg;

    localparam int BLK_W = 132;
    localparam int PAY_W = 128;
    localparam int HDR_W = 4;

    localparam logic [HDR_W-1:0] HDR_DATA = 4'b1100;
    localparam logic [HDR_W-1:0] HDR_CTRL = 4'b0011;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        CHECK     = 2'd2,
        LOCKED    = 2'd3
    } lock_state_t;

    function automatic logic hdr_is_good(input logic [HDR_W-1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/dfflr.sv
// rtl/dfflr.sv - load-enabled flop primitive, asynchronous active-high reset variant
module dfflr #(
    parameter int           W   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gearbox_block_lock.sv
// rtl/gearbox_block_lock.sv - header-based block lock, slip control and aligned-block forwarding
module gearbox_block_lock
    import gearbox_pkg::*;
#(
    parameter int LOCK_GOOD = 64,
    parameter int WIN_LEN   = 1024,
    parameter int WIN_BAD   = 16,
    parameter int SLIP_WAIT = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BLK_W-1:0] blk_in,
    input  logic             blk_valid,
    output logic             slip,
    output logic             block_lock,
    output logic [PAY_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_ctrl,
    output logic [15:0]      bad_hdr_cnt
);

    localparam logic [6:0] GOOD_LAST = 7'(LOCK_GOOD - 1);
    localparam logic [9:0] WIN_LAST  = 10'(WIN_LEN - 1);
    localparam logic [4:0] BAD_LAST  = 5'(WIN_BAD - 1);
    localparam logic [5:0] WAIT_LAST = 6'(SLIP_WAIT - 1);

    lock_state_t state_q, state_d;
    logic [6:0]  good_cnt_q, good_cnt_d;
    logic [9:0]  blk_cnt_q, blk_cnt_d;
    logic [4:0]  bad_cnt_q, bad_cnt_d;
    logic [5:0]  wait_cnt_q, wait_cnt_d;

    logic             slip_q, slip_d;
    logic             block_lock_q, block_lock_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_ctrl_q, dout_ctrl_d;
    logic [PAY_W-1:0] dout_q, dout_d;
    logic [15:0]      bad_hdr_cnt_q, bad_hdr_cnt_d;

    logic [HDR_W-1:0] hdr;
    logic             hdr_good;

    assign hdr      = blk_in[BLK_W-1:PAY_W];
    assign hdr_good = hdr_is_good(hdr);

    always_comb begin
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        blk_cnt_d     = blk_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        slip_d        = 1'b0;
        block_lock_d  = block_lock_q;
        dout_valid_d  = 1'b0;
        dout_ctrl_d   = (hdr == HDR_CTRL);
        dout_d        = blk_in[PAY_W-1:0];
        bad_hdr_cnt_d = bad_hdr_cnt_q;

        if (blk_valid) begin
            case (state_q)
                HUNT: begin
                    if (hdr_good) begin
                        state_d    = CHECK;
                        good_cnt_d = 7'd1;
                    end else begin
                        state_d    = SLIP_HOLD;
                        slip_d     = 1'b1;
                        wait_cnt_d = '0;
                    end
                end
                SLIP_HOLD: begin
                    // Gearbox output is garbage while it refills after a slip.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = HUNT;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 6'd1;
                    end
                end
                CHECK: begin
                    if (!hdr_good) begin
                        state_d    = SLIP_HOLD;
                        slip_d     = 1'b1;
                        wait_cnt_d = '0;
                        good_cnt_d = '0;
                    end else if (good_cnt_q == GOOD_LAST) begin
                        state_d      = LOCKED;
                        block_lock_d = 1'b1;
                        good_cnt_d   = '0;
                        blk_cnt_d    = '0;
                        bad_cnt_d    = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 7'd1;
                    end
                end
                LOCKED: begin
                    if (!hdr_good && bad_hdr_cnt_q != 16'hFFFF) begin
                        bad_hdr_cnt_d = bad_hdr_cnt_q + 16'd1;
                    end
                    // Lock loss wins over the window-end clear on the same block.
                    if (!hdr_good && bad_cnt_q == BAD_LAST) begin
                        state_d      = SLIP_HOLD;
                        block_lock_d = 1'b0;
                        slip_d       = 1'b1;
                        wait_cnt_d   = '0;
                        blk_cnt_d    = '0;
                        bad_cnt_d    = '0;
                    end else begin
                        dout_valid_d = hdr_good;
                        if (blk_cnt_q == WIN_LAST) begin
                            blk_cnt_d = '0;
                            bad_cnt_d = '0;
                        end else begin
                            blk_cnt_d = blk_cnt_q + 10'd1;
                            bad_cnt_d = bad_cnt_q + {4'd0, !hdr_good};
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            good_cnt_q <= '0;
            blk_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    dfflr #(.W(1)) u_slip_ff (
        .clk(clk), .rst(rst), .en(1'b1), .d(slip_d), .q(slip_q)
    );

    dfflr #(.W(1)) u_lock_ff (
        .clk(clk), .rst(rst), .en(1'b1), .d(block_lock_d), .q(block_lock_q)
    );

    dfflr #(.W(1)) u_dout_valid_ff (
        .clk(clk), .rst(rst), .en(1'b1), .d(dout_valid_d), .q(dout_valid_q)
    );

    dfflr #(.W(1)) u_dout_ctrl_ff (
        .clk(clk), .rst(rst), .en(dout_valid_d), .d(dout_ctrl_d), .q(dout_ctrl_q)
    );

    dfflr #(.W(PAY_W)) u_dout_ff (
        .clk(clk), .rst(rst), .en(dout_valid_d), .d(dout_d), .q(dout_q)
    );

    dfflr #(.W(16)) u_bad_hdr_cnt_ff (
        .clk(clk), .rst(rst), .en(1'b1), .d(bad_hdr_cnt_d), .q(bad_hdr_cnt_q)
    );

    assign slip        = slip_q;
    assign block_lock  = block_lock_q;
    assign dout_valid  = dout_valid_q;
    assign dout_ctrl   = dout_ctrl_q;
    assign dout        = dout_q;
    assign bad_hdr_cnt = bad_hdr_cnt_q;

endmodule

// File: tb/tb_gearbox_block_lock.sv
// tb/tb_gearbox_block_lock.sv - randomized and directed checks of gearbox_block_lock against a behavioural model
module tb_gearbox_block_lock;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [131:0] blk_in = '0;
    logic         blk_valid = 1'b0;
    logic         slip;
    logic         block_lock;
    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ctrl;
    logic [15:0]  bad_hdr_cnt;

    gearbox_block_lock dut (
        .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
        .slip(slip), .block_lock(block_lock), .dout(dout), .dout_valid(dout_valid),
        .dout_ctrl(dout_ctrl), .bad_hdr_cnt(bad_hdr_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int slip_seen = 0;

    // Model: mode 0 hunting, 1 waiting for refill, 2 confirming, 3 locked.
    int           m_mode, m_good, m_blk, m_bad, m_wait;
    logic         e_slip, e_lock, e_dv, e_ctrl;
    logic [127:0] e_dout;
    int           e_badhdr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_blk = 0; m_bad = 0; m_wait = 0;
        e_slip = 0; e_lock = 0; e_dv = 0; e_ctrl = 0; e_dout = '0; e_badhdr = 0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] h, input logic [127:0] p);
        bit good;
        good   = (h == 4'b1100) || (h == 4'b0011);
        e_slip = 0;
        e_dv   = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (good) begin m_mode = 2; m_good = 1; end
                else begin e_slip = 1; m_mode = 1; m_wait = 0; end
            end else if (m_mode == 1) begin
                m_wait++;
                if (m_wait == 33) begin m_mode = 0; m_wait = 0; end
            end else if (m_mode == 2) begin
                if (good) begin
                    m_good++;
                    if (m_good == 64) begin
                        m_mode = 3; e_lock = 1; m_blk = 0; m_bad = 0; m_good = 0;
                    end
                end else begin
                    e_slip = 1; m_mode = 1; m_wait = 0; m_good = 0;
                end
            end else begin
                m_blk++;
                if (!good) begin
                    m_bad++;
                    if (e_badhdr < 65535) e_badhdr++;
                end
                if (m_bad == 16) begin
                    e_lock = 0; e_slip = 1; m_mode = 1; m_wait = 0; m_blk = 0; m_bad = 0;
                end else begin
                    if (good) begin e_dv = 1; e_dout = p; e_ctrl = (h == 4'b0011); end
                    if (m_blk == 1024) begin m_blk = 0; m_bad = 0; end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("slip", slip, e_slip);
        chk("block_lock", block_lock, e_lock);
        chk("dout_valid", dout_valid, e_dv);
        chk("bad_hdr_cnt", bad_hdr_cnt, e_badhdr[15:0]);
        if (e_dv) begin
            chk("dout", dout, e_dout);
            chk("dout_ctrl", dout_ctrl, e_ctrl);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] h, input logic [127:0] p);
        blk_valid = v;
        blk_in    = {h, p};
        @(posedge clk);
        model_step(v, h, p);
        @(negedge clk);
        if (slip) slip_seen++;
        compare_all();
    endtask

    function automatic logic [127:0] rnd_pay();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [3:0] rnd_bad();
        logic [3:0] h;
        h = 4'($urandom_range(0, 15));
        while (h == 4'b1100 || h == 4'b0011) h = 4'($urandom_range(0, 15));
        return h;
    endfunction

    function automatic logic [3:0] rnd_good();
        return ($urandom_range(0, 1) == 1) ? 4'b0011 : 4'b1100;
    endfunction

    task automatic good_blk();
        step(1'b1, 4'b1100, rnd_pay());
    endtask

    task automatic do_reset();
        blk_valid = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic acquire_lock();
        for (int i = 0; i < 64; i++) good_blk();
    endtask

    int pbad [6] = '{0, 1, 3, 8, 30, 2};
    int nvalid;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_dout", dout, 128'd0);
        chk("reset_dout_ctrl", dout_ctrl, 1'b0);
        rst = 1'b0;

        // Aligned stream: lock after the 64th block, block 65 forwarded.
        for (int i = 0; i < 63; i++) good_blk();
        chk("lock_after_63", block_lock, 1'b0);
        good_blk();
        chk("lock_after_64", block_lock, 1'b1);
        chk("no_fwd_64th", dout_valid, 1'b0);
        step(1'b1, 4'b1100, {16{8'hA5}});
        chk("blk65_dout", dout, {16{8'hA5}});
        chk("blk65_valid", dout_valid, 1'b1);
        chk("blk65_ctrl", dout_ctrl, 1'b0);

        // Locked loss: 15 bad holds lock, 16th drops it.
        for (int b = 0; b < 15; b++) begin
            repeat (3) good_blk();
            step(1'b1, rnd_bad(), rnd_pay());
        end
        chk("loss_cnt15", bad_hdr_cnt, 16'd15);
        chk("loss_lock15", block_lock, 1'b1);
        good_blk();
        step(1'b1, 4'b0101, rnd_pay());
        chk("loss_lock16", block_lock, 1'b0);
        chk("loss_slip16", slip, 1'b1);
        chk("loss_dv16", dout_valid, 1'b0);
        good_blk();
        chk("slip_single", slip, 1'b0);

        // Window rollover, then 16th bad on the last block of a window.
        do_reset();
        acquire_lock();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1024; i++) begin
                if (i >= 100 && i < 115) step(1'b1, rnd_bad(), rnd_pay());
                else step(1'b1, rnd_good(), rnd_pay());
            end
        end
        chk("roll_lock", block_lock, 1'b1);
        chk("roll_cnt30", bad_hdr_cnt, 16'd30);
        for (int i = 0; i < 1023; i++) begin
            if (i < 15) step(1'b1, rnd_bad(), rnd_pay());
            else good_blk();
        end
        chk("edge_lock_held", block_lock, 1'b1);
        step(1'b1, rnd_bad(), rnd_pay());
        chk("edge_lock_lost", block_lock, 1'b0);
        chk("edge_cnt46", bad_hdr_cnt, 16'd46);

        // Misaligned start: three bad starts give three slips.
        do_reset();
        slip_seen = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 4'b1010, rnd_pay());
            if (k < 2) begin
                nvalid = 0;
                while (nvalid < 33) begin
                    if ($urandom_range(0, 9) == 0) step(1'b0, 4'($urandom), rnd_pay());
                    else begin step(1'b1, 4'($urandom), rnd_pay()); nvalid++; end
                end
            end
        end
        chk("slip_count3", slip_seen, 3);

        // Bubbles during acquisition: exactly 64 valid good blocks still needed.
        do_reset();
        nvalid = 0;
        for (int c = 0; nvalid < 63; c++) begin
            if (c % 33 == 32) step(1'b0, 4'b1100, rnd_pay());
            else begin good_blk(); nvalid++; end
        end
        step(1'b0, 4'b1100, rnd_pay());
        chk("bubble_lock63", block_lock, 1'b0);
        good_blk();
        chk("bubble_lock64", block_lock, 1'b1);

        // Async reset in LOCKED mid-stream.
        repeat (5) good_blk();
        blk_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_lock0", block_lock, 1'b0);
        chk("async_dv0", dout_valid, 1'b0);
        chk("async_dout0", dout, 128'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 63; i++) good_blk();
        chk("relock_63", block_lock, 1'b0);
        good_blk();
        chk("relock_64", block_lock, 1'b1);

        // Random segments with varying bad-header density and gearbox bubbles.
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 32) == 0) step(1'b0, 4'($urandom), rnd_pay());
                else if ($urandom_range(0, 99) < pbad[s]) step(1'b1, rnd_bad(), rnd_pay());
                else step(1'b1, rnd_good(), rnd_pay());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1);
    end

endmodule
